// File: rtl/fetch_stage.sv
// PC register plus IF/ID pipeline register; drives instruction-memory address, captures word and PC+4.
// Optional perf counters (FetchCount/BubbleCount) compiled in with FETCH_PERF_COUNT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        RedirectEn,
  input  logic [31:0] RedirectPC,
  output logic [31:0] InstrAddr,
  input  logic [31:0] InstrIn,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PCPlus4,
`ifdef FETCH_PERF_COUNT_EN
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount,
`endif
  output logic        IFID_Valid
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
  localparam ifid_t       BUBBLE     = '{instr: NOP_WORD, pc_plus4: 32'h0, valid: 1'b0};

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  ifid_t       ifid;
  logic        kill;
  logic        load;

  assign pc_plus4 = pc + 32'd4;
  // A redirect squashes the in-flight fetch exactly like a flush.
  assign kill     = Flush | RedirectEn;
  assign load     = ~kill & ~Stall;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)            pc <= RESET_PC & ALIGN_MASK;
    else if (RedirectEn) pc <= RedirectPC & ALIGN_MASK;
    else if (!Stall)     pc <= pc_plus4;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)      ifid <= BUBBLE;
    else if (kill) ifid <= BUBBLE;
    else if (load) ifid <= '{instr: InstrIn, pc_plus4: pc_plus4, valid: 1'b1};
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (load) fetch_cnt  <= fetch_cnt + 32'd1;
      if (kill) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign FetchCount  = fetch_cnt;
  assign BubbleCount = bubble_cnt;
`endif

  assign InstrAddr    = pc;
  assign IFID_Instr   = ifid.instr;
  assign IFID_PCPlus4 = ifid.pc_plus4;
  assign IFID_Valid   = ifid.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns Address[8:2]*4.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        Clk = 1'b0;
  logic        Rst, rst_w;
  logic        Stall, Flush, RedirectEn;
  logic [31:0] RedirectPC;
  logic [31:0] addr, instr_in, ifid_instr, ifid_pc4;
  logic        ifid_valid;
  logic [31:0] addr_w, instr_w, ifid_instr_w, ifid_pc4_w;
  logic        ifid_valid_w;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fcnt, bcnt, fcnt_w, bcnt_w;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 Clk = ~Clk;

  assign instr_in = {23'd0, addr[8:2], 2'b00};
  assign instr_w  = {23'd0, addr_w[8:2], 2'b00};

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_WORD(NOP)) u_dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
    .RedirectEn(RedirectEn), .RedirectPC(RedirectPC),
    .InstrAddr(addr), .InstrIn(instr_in),
    .IFID_Instr(ifid_instr), .IFID_PCPlus4(ifid_pc4),
`ifdef FETCH_PERF_COUNT_EN
    .FetchCount(fcnt), .BubbleCount(bcnt),
`endif
    .IFID_Valid(ifid_valid)
  );

  // Low bits of RESET_PC set on purpose: they must be ignored.
  fetch_stage #(.RESET_PC(32'hFFFF_FFFF), .NOP_WORD(NOP)) u_wrap (
    .Clk(Clk), .Rst(rst_w), .Stall(1'b0), .Flush(1'b0),
    .RedirectEn(1'b0), .RedirectPC(32'h0),
    .InstrAddr(addr_w), .InstrIn(instr_w),
    .IFID_Instr(ifid_instr_w), .IFID_PCPlus4(ifid_pc4_w),
`ifdef FETCH_PERF_COUNT_EN
    .FetchCount(fcnt_w), .BubbleCount(bcnt_w),
`endif
    .IFID_Valid(ifid_valid_w)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic ifid(input string tag, input logic [31:0] a, input logic [31:0] i,
                      input logic [31:0] p4, input logic v);
    chk({tag, ".addr"},  addr, a);
    chk({tag, ".instr"}, ifid_instr, i);
    chk({tag, ".pc4"},   ifid_pc4, p4);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
  endtask

  task automatic do_reset();
    Rst = 1'b0; Stall = 1'b0; Flush = 1'b0; RedirectEn = 1'b0; RedirectPC = '0;
    step();
    Rst = 1'b1;
  endtask

  initial begin
    rst_w = 1'b0;
    do_reset();
    Rst = 1'b0;
    #1;
    ifid("rst", 32'h0, NOP, 32'h0, 1'b0);
    Rst = 1'b1;

    // Free run then stall at 0x10
    step(); ifid("run1", 32'h4, 32'h0, 32'h4, 1'b1);
    step(); ifid("run2", 32'h8, 32'h4, 32'h8, 1'b1);
    step(); ifid("run3", 32'hC, 32'h8, 32'hC, 1'b1);
    step(); ifid("run4", 32'h10, 32'hC, 32'h10, 1'b1);
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(); ifid("stall", 32'h10, 32'hC, 32'h10, 1'b1);
    end
    Stall = 1'b0;
    step(); ifid("unstall", 32'h14, 32'h10, 32'h14, 1'b1);

    // Redirect at PC=0x8 to unaligned 0x43
    do_reset();
    step(); step();
    chk("redir.pre", addr, 32'h8);
    RedirectEn = 1'b1; RedirectPC = 32'h43;
    step(); ifid("redir", 32'h40, NOP, 32'h0, 1'b0);
    RedirectEn = 1'b0;
    step(); ifid("redir.tgt", 32'h44, 32'h40, 32'h44, 1'b1);
    // Redirect overrides stall
    RedirectEn = 1'b1; Stall = 1'b1; RedirectPC = 32'h102;
    step(); ifid("redir.stall", 32'h100, NOP, 32'h0, 1'b0);
    RedirectEn = 1'b0; Stall = 1'b0;
    step(); ifid("redir.stall.tgt", 32'h104, 32'h100, 32'h104, 1'b1);

    // Flush + stall at PC=0x20
    do_reset();
    for (int k = 0; k < 8; k++) step();
    chk("flush.pre", addr, 32'h20);
    Flush = 1'b1; Stall = 1'b1;
    step(); ifid("flush", 32'h20, NOP, 32'h0, 1'b0);
    Flush = 1'b0; Stall = 1'b0;
    step(); ifid("flush.refetch", 32'h24, 32'h20, 32'h24, 1'b1);
`ifdef FETCH_PERF_COUNT_EN
    chk("flush.fcnt", fcnt, 32'd9);
    chk("flush.bcnt", bcnt, 32'd1);
`endif

    // PC wrap from RESET_PC=0xFFFF_FFFC
    chk("wrap.rst", addr_w, 32'hFFFF_FFFC);
    rst_w = 1'b1;
    step();
    chk("wrap.pc4",   ifid_pc4_w, 32'h0);
    chk("wrap.instr", ifid_instr_w, 32'h1FC);
    chk("wrap.addr",  addr_w, 32'h0);
    step();
    chk("wrap.instr2", ifid_instr_w, 32'h0);
    chk("wrap.pc4b",   ifid_pc4_w, 32'h4);

    // Asynchronous reset mid-stall at PC=0x30
    do_reset();
    for (int k = 0; k < 12; k++) step();
    chk("arst.pre", addr, 32'h30);
    Stall = 1'b1;
    step(); step();
    #3;
    Rst = 1'b0;
    #1;
    ifid("arst", 32'h0, NOP, 32'h0, 1'b0);
`ifdef FETCH_PERF_COUNT_EN
    chk("arst.fcnt", fcnt, 32'd0);
    chk("arst.bcnt", bcnt, 32'd0);
`endif
    Stall = 1'b0;
    step();
    Rst = 1'b1;
    for (int k = 0; k < 5; k++) step();
    ifid("arst.run5", 32'h14, 32'h10, 32'h14, 1'b1);
`ifdef FETCH_PERF_COUNT_EN
    chk("perf.fcnt5", fcnt, 32'd5);
    chk("perf.bcnt0", bcnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
